// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth sequential signed multiplier: one add/sub plus arithmetic shift per clock.
// Optional BOOTH_ZERO_SKIP_EN: zero operands finish straight from IDLE in one cycle.
module booth_seq_multiplier #(
  parameter int BITS = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [BITS-1:0]     multiplicand,
  input  logic [BITS-1:0]     multiplier,
  output logic                busy,
  output logic                done,
  output logic [2*BITS-1:0]   product
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [BITS:0]   a_reg;
  logic [BITS:0]   m_reg;
  logic [BITS-1:0] q_reg;
  logic            q_m1_reg;
  logic [CW-1:0]   count_reg;

  logic [BITS:0]   addend;
  logic            carry_in;
  logic [BITS:0]   sum;
  logic [BITS:0]   a_next;
  logic [BITS-1:0] q_next;
  logic            q_m1_next;

  // Subtraction reuses the adder as A + ~M + 1; the extra bit keeps -M exact for the most negative M.
  always_comb begin
    addend   = '0;
    carry_in = 1'b0;
    case ({q_reg[0], q_m1_reg})
      2'b01: addend = m_reg;
      2'b10: begin
        addend   = ~m_reg;
        carry_in = 1'b1;
      end
      default: addend = '0;
    endcase
    sum       = a_reg + addend + {{BITS{1'b0}}, carry_in};
    a_next    = {sum[BITS], sum[BITS:1]};
    q_next    = {sum[0], q_reg[BITS-1:1]};
    q_m1_next = q_reg[0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      q_m1_reg  <= 1'b0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= '0;
            q_reg     <= multiplier;
            q_m1_reg  <= 1'b0;
            m_reg     <= {multiplicand[BITS-1], multiplicand};
            count_reg <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
            if (multiplicand == '0 || multiplier == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
              product   <= '0;
            end else begin
              state_reg <= CALC;
              busy      <= 1'b1;
            end
`else
            state_reg <= CALC;
            busy      <= 1'b1;
`endif
          end
        end
        CALC: begin
          a_reg     <= a_next;
          q_reg     <= q_next;
          q_m1_reg  <= q_m1_next;
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(BITS - 1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            product   <= {a_next[BITS-1:0], q_next};
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed corner cases, ignored start,
// mid-operation reset and random operands against a plain signed-multiply model.
module tb_booth_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int tests = 0;
  int fails = 0;
  logic [63:0] prev_product;

  booth_seq_multiplier #(.BITS(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint a;
    longint b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // glitch_at: cycle whose closing edge sees a stray start; rst_at: cycle whose closing edge sees reset_n low.
  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input int glitch_at, input int rst_at);
    int exp_done;
    int done_at;
    int done_cnt;
    int busy_cnt;
    int overlap;
    logic [63:0] exp_prod;
    exp_prod = ref_mul(m, q);
    exp_done = 33;
`ifdef BOOTH_ZERO_SKIP_EN
    if (m == 32'd0 || q == 32'd0) exp_done = 1;
`endif
    done_at  = 0;
    done_cnt = 0;
    busy_cnt = 0;
    overlap  = 0;
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    step();
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (busy && done) overlap++;
      if (rst_at != 0 && n > rst_at) begin
        if (n == rst_at + 1) begin
          check({tag, "_rst_busy"}, 64'(busy), 64'd0);
          check({tag, "_rst_done"}, 64'(done), 64'd0);
          check({tag, "_rst_product"}, product, 64'd0);
        end
      end else if (n < exp_done && n == 1) begin
        check({tag, "_hold"}, product, prev_product);
      end
      start        = (n == glitch_at);
      multiplicand = (n == glitch_at) ? 32'd2 : $urandom;
      multiplier   = (n == glitch_at) ? 32'd2 : $urandom;
      reset_n      = (n != rst_at);
      step();
    end
    start = 1'b0;
    check({tag, "_overlap"}, 64'(overlap), 64'd0);
    if (rst_at != 0) begin
      check({tag, "_rst_no_done"}, 64'(done_cnt), 64'd0);
      check({tag, "_rst_busy_cycles"}, 64'(busy_cnt), 64'(rst_at));
      check({tag, "_rst_product_end"}, product, 64'd0);
      prev_product = 64'd0;
    end else begin
      check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_done - 1));
      check({tag, "_product"}, product, exp_prod);
      prev_product = exp_prod;
    end
    $display("[TB] %s m=%h q=%h product=%h expected=%h done_at=%0d", tag, m, q, product,
             (rst_at != 0) ? 64'd0 : exp_prod, done_at);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;
    prev_product = 64'd0;
    step();
    step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    reset_n = 1'b1;
    step();

    run_op("m3_q5", 32'd3, 32'd5, 0, 0);
    check("m3_q5_const", product, 64'h0000_0000_0000_000F);
    run_op("m_neg7_q6", 32'hFFFF_FFF9, 32'd6, 0, 0);
    check("m_neg7_q6_const", product, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("min_min", 32'h8000_0000, 32'h8000_0000, 0, 0);
    check("min_min_const", product, 64'h4000_0000_0000_0000);
    run_op("min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("min_neg1_const", product, 64'h0000_0000_8000_0000);
    run_op("neg1_min", 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    check("neg1_min_const", product, 64'h0000_0000_8000_0000);
    run_op("ignored_start", 32'd7, 32'd9, 10, 0);
    check("ignored_start_const", product, 64'd63);
    run_op("mid_reset", 32'd7, 32'd9, 0, 15);
    run_op("zero_m", 32'd0, 32'd123, 0, 0);
    run_op("zero_q", 32'h1234_5678, 32'd0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("rand%0d", i), $urandom, $urandom, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Radix-2 Booth sequential signed multiplier for the ALU datapath; the MUL stage beside the carry-lookahead adder.
- Each cycle it feeds an accumulator and ±multiplicand into a (BITS+1)-wide add/sub path, then consumes the sum.
- Produces a 2*BITS-bit product that the Z register pair (ZHI/ZLO) captures on done.

Parameters:
BITS, 32, operand width; product is 2*BITS.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  request to begin; sampled only in IDLE
multiplicand  input  BITS  signed two's-complement M; sampled on accepted start
multiplier  input  BITS  signed two's-complement Q; sampled on accepted start
busy  output  1  high while in CALC
done  output  1  one-cycle pulse in DONE; product valid
product  output  2*BITS  signed result; held until the next accepted start completes

Behaviour:
- Reset: reset_n low at a rising edge forces IDLE.
  - busy=0, done=0, product=0.
  - All internal registers (A, Q, q_m1, M, count) are cleared.
  - A reset that arrives mid-operation aborts the operation with no partial product.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge T loads A=0 (BITS+1 bits), Q=multiplier, q_m1=0, M=sign-extended multiplicand (BITS+1 bits), count=0.
  - State goes to CALC and busy=1 from T+1.
  - start=0 stays in IDLE.
- CALC, one iteration per edge:
  - {Q[0],q_m1}=01: A=A+M.
  - {Q[0],q_m1}=10: A=A+~M+1, computed as a (BITS+1)-bit add with carry-in 1.
  - {Q[0],q_m1}=00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by 1 (A MSB replicated), count++.
  - All adds are BITS+1 wide; carry-out is discarded. The extra bit makes -M exact for M=-2^(BITS-1).
  - When the edge completing iteration BITS occurs (edge T+BITS), state goes to DONE and product={A[BITS-1:0],Q} is registered.
- DONE: done=1, busy=0 for exactly one cycle (T+BITS+1), then IDLE.
- Latency: start edge T → done high in cycle T+BITS+1.
- start is ignored in CALC and DONE, with no queuing. Inputs may change after the accepted start without effect.
- product changes only on entry to DONE or on reset.
- busy and done are never high together.

Optional Feature:
Macro: BOOTH_ZERO_SKIP_EN
- Defined:
  - An accepted start with multiplicand==0 or multiplier==0 goes directly IDLE→DONE.
  - product=0 is registered on that edge and done pulses at T+1; busy stays 0.
  - Non-zero operands behave as without the macro.
- Undefined:
  - Zero operands take the full BITS iterations.
  - The result is still 0, with done at T+BITS+1.

Test Plan:
- BITS=32, start with M=3, Q=5 → busy high cycles T+1..T+32, done pulse at T+33, product=64'h0000_0000_0000_000F.
- M=-7 (32'hFFFF_FFF9), Q=6 → product=64'hFFFF_FFFF_FFFF_FFD6 (-42).
- M=32'h8000_0000, Q=32'h8000_0000 → product=64'h4000_0000_0000_0000.
- M=32'h8000_0000, Q=32'hFFFF_FFFF → product=64'h0000_0000_8000_0000.
- Extreme-operand check: M=32'hFFFF_FFFF, Q=32'h8000_0000 → product=64'h0000_0000_8000_0000.
- Start 7×9, pulse start with M=2, Q=2 at T+10 → that start is ignored; done at T+33 with product=63. Then a second run of 7×9 with reset_n low at T+15 → busy=0, done=0, product=0 from T+16, and no done pulse at T+33.
- M=0, Q=123 → done at T+33 with product=0 if BOOTH_ZERO_SKIP_EN undefined; done at T+1, busy never high, product=0 if defined.
